// File: rtl/multiplier_pkg.sv
// Types and constants shared by the multiplier/reduction controllers.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned DILITHIUM_Q = 32'd8380417;
    localparam int          REQ_MAX     = 8;

endpackage

// File: rtl/params_pkg.sv
// Shared datapath parameters for the reduction clients and the reduction unit.
package params_pkg;

    localparam int DATA_LENGTH = 32;

endpackage

// File: rtl/reduction_arb_select.sv
// Combinational winner picker: one-hot grant plus binary index of the winner.
// REDUCTION_ARB_RR_EN selects round-robin search from ptr; otherwise lowest index wins.
module reduction_arb_select #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef REDUCTION_ARB_RR_EN
    input  logic [IDX_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

`ifdef REDUCTION_ARB_RR_EN
    logic found;
    int   cand;

    // Walk the requesters starting at ptr, wrapping once around.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/reduction_arbiter.sv
// Shares one modular reduction unit between NUM_REQ requesters, one transaction at a time.
// Define REDUCTION_ARB_RR_EN for round-robin arbitration (default: fixed priority, index 0 first).
module reduction_arbiter
    import params_pkg::*;
    import multiplier_pkg::*;
#(
    parameter int          NUM_REQ = 2,
    parameter int unsigned MOD     = DILITHIUM_Q
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    input  logic [NUM_REQ-1:0]             resp_ready_i,
    output logic [DATA_LENGTH-1:0]         resp_result_o,
    output logic                           busy_o,
    output logic                           red_start_o,
    output logic [DATA_LENGTH-1:0]         red_x_o,
    output logic [DATA_LENGTH-1:0]         red_m_o,
    input  logic [DATA_LENGTH-1:0]         red_result_i,
    input  logic                           red_valid_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state, next_state;
    logic [NUM_REQ-1:0]     sel_grant;
    logic [IDX_W-1:0]       sel_idx;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic [DATA_LENGTH-1:0] sel_x;
    logic                   accept;
    logic                   capture;
    logic                   handshake;

`ifdef REDUCTION_ARB_RR_EN
    logic [IDX_W-1:0] ptr;
`endif

    reduction_arb_select #(
        .NUM_REQ(NUM_REQ)
    ) u_select (
        .req  (req_valid_i),
`ifdef REDUCTION_ARB_RR_EN
        .ptr  (ptr),
`endif
        .grant(sel_grant),
        .idx  (sel_idx)
    );

    assign sel_x   = req_x_i[int'(sel_idx)*DATA_LENGTH +: DATA_LENGTH];
    assign red_m_o = DATA_LENGTH'(MOD);

    always_comb begin
        next_state  = state;
        req_ready_o = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                    // Keep the accept strobe quiet while reset is held.
                    if (rst_ni) begin
                        req_ready_o = sel_grant;
                    end
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (red_valid_i) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i[grant_idx]) begin
                    handshake  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and transaction context.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_oh      <= '0;
            grant_idx     <= '0;
            red_x_o       <= '0;
            red_start_o   <= 1'b0;
            resp_valid_o  <= '0;
            resp_result_o <= '0;
            busy_o        <= 1'b0;
        end else begin
            red_start_o <= accept;
            busy_o      <= (next_state != IDLE);
            if (accept) begin
                grant_oh  <= sel_grant;
                grant_idx <= sel_idx;
                red_x_o   <= sel_x;
            end
            if (capture) begin
                resp_result_o <= red_result_i;
                resp_valid_o  <= grant_oh;
            end else if (handshake) begin
                resp_valid_o  <= '0;
            end
        end
    end

`ifdef REDUCTION_ARB_RR_EN
    // Next search starts just after the requester that completed last.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (handshake) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reduction_arbiter.sv
// Directed bench for reduction_arbiter with a cycle-level transaction model and a latency-L unit model.
module tb_reduction_arbiter;
    import params_pkg::*;

    localparam int N  = 2;
    localparam int DW = DATA_LENGTH;
    localparam int Q  = 8380417;
    localparam int L  = 3;
`ifdef REDUCTION_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*DW-1:0] req_x_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    resp_valid_o;
    logic [N-1:0]    resp_ready_i = '1;
    logic [DW-1:0]   resp_result_o;
    logic            busy_o;
    logic            red_start_o;
    logic [DW-1:0]   red_x_o;
    logic [DW-1:0]   red_m_o;
    logic [DW-1:0]   red_result_i;
    logic            red_valid_i;
    logic            unit_v = 1'b0;
    logic            spur = 1'b0;
    logic [DW-1:0]   unit_res = '0;
    logic [DW-1:0]   junk = 32'hDEADBEEF;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int            grant_q[$];
    logic [DW-1:0] res_q[$];
    int            acc_cyc = 0, start_cyc = 0, rise_cyc = 0;

    assign red_valid_i  = (unit_v & rst_ni) | spur;
    assign red_result_i = spur ? junk : unit_res;

    reduction_arbiter #(.NUM_REQ(N), .MOD(Q)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_x_i      (req_x_i),
        .req_ready_o  (req_ready_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_result_o(resp_result_o),
        .busy_o       (busy_o),
        .red_start_o  (red_start_o),
        .red_x_o      (red_x_o),
        .red_m_o      (red_m_o),
        .red_result_i (red_result_i),
        .red_valid_i  (red_valid_i)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int lst);
        int start = RR_EN ? lst + 1 : 0;
        for (int k = 0; k < N; k++) begin
            int i = (start + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reduction unit stand-in: result = x mod q, L cycles after the start pulse.
    int            due = -1;
    logic [DW-1:0] pend = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_ni) due = -1;
        else if (red_start_o) begin
            due  = cyc + L;
            pend = DW'(red_x_o % Q);
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        unit_v = (cyc == due);
        if (cyc == due) unit_res = pend;
    end

    // Transaction model and per-cycle compare; also logs DUT events for literal checks.
    initial begin
        bit            inflight = 0, rphase = 0;
        int            owner = 0, t_acc = 0, last = N - 1, p;
        logic [DW-1:0] mx = '0, mres = '0;
        logic [N-1:0]  exp_ready, prev_rv;
        prev_rv = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                inflight = 0; rphase = 0; last = N - 1; prev_rv = '0;
                chk("rst_req_ready", req_ready_o, 0);
                chk("rst_resp_valid", resp_valid_o, 0);
                chk("rst_resp_result", resp_result_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_start", red_start_o, 0);
                chk("rst_red_x", red_x_o, 0);
            end else begin
                p = pick(req_valid_i, last);
                exp_ready = (!inflight && p >= 0) ? N'(1 << p) : '0;
                chk("req_ready", req_ready_o, exp_ready);
                chk("busy", busy_o, inflight);
                chk("red_start", red_start_o, inflight && (cyc == t_acc + 1));
                chk("resp_valid", resp_valid_o, rphase ? N'(1 << owner) : '0);
                chk("red_m", red_m_o, Q);
                if (rphase) chk("resp_result", resp_result_o, mres);
                if (inflight) chk("red_x", red_x_o, mx);

                for (int i = 0; i < N; i++) if (req_ready_o[i]) grant_q.push_back(i);
                if (req_ready_o != 0) acc_cyc = cyc;
                if (red_start_o) start_cyc = cyc;
                if (resp_valid_o != 0 && prev_rv == 0) rise_cyc = cyc;
                if ((resp_valid_o & resp_ready_i) != 0) res_q.push_back(resp_result_o);
                prev_rv = resp_valid_o;

                if (exp_ready != 0) begin
                    inflight = 1; owner = p; t_acc = cyc;
                    mx = req_x_i[p*DW +: DW];
                end else if (inflight && !rphase && cyc >= t_acc + 2 && red_valid_i) begin
                    rphase = 1; mres = red_result_i;
                end else if (rphase && resp_ready_i[owner]) begin
                    inflight = 0; rphase = 0; last = owner;
                end
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int idx, logic [DW-1:0] x);
        bit ok = 0;
        req_x_i[idx*DW +: DW] = x;
        req_valid_i[idx] = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready_o[idx]) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout: requester %0d got no ready, required within 50 cycles", idx);
        end
        step();
        req_valid_i[idx] = 1'b0;
    endtask

    task automatic wait_hs(int idx);
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (resp_valid_o[idx] && resp_ready_i[idx]) ok = 1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL resp_timeout: requester %0d got no response, required within 100 cycles", idx);
        end
        step();
    endtask

    initial begin
        int exp_g[4];
        logic [DW-1:0] exp_r[4];
        bit ok;
`ifdef REDUCTION_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
        exp_r = '{0, 8380416, 0, 8380416};
`else
        exp_g = '{0, 0, 0, 0};
        exp_r = '{0, 0, 0, 0};
`endif
        step(3);
        chk("reset_busy_lit", busy_o, 0);
        chk("reset_resp_valid_lit", resp_valid_o, 0);
        rst_ni = 1'b1;
        step(2);

        // Both requesters contend continuously.
        grant_q.delete(); res_q.delete();
        req_x_i = {32'd8380416, 32'd16760834};
        req_valid_i = 2'b11;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (res_q.size() >= 4) ok = 1;
        end
        step();
        req_valid_i = 2'b00;
        chk("contend_done", ok, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contend_grant%0d", i), grant_q[i], exp_g[i]);
            chk($sformatf("contend_result%0d", i), res_q[i], exp_r[i]);
        end
        step(3);

        // Single request: latency and reduction result.
        res_q.delete();
        send(0, 32'd8380418);
        wait_hs(0);
        chk("single_result", res_q[0], 1);
        chk("single_start_lat", start_cyc - acc_cyc, 1);
        chk("single_resp_lat", rise_cyc - acc_cyc, 5);
        step(2);

        // Response stall on requester 1 while requester 0 waits.
        resp_ready_i[1] = 1'b0;
        send(1, 32'd123);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (resp_valid_o[1]) ok = 1;
        end
        chk("stall_resp_seen", ok, 1);
        step();
        req_x_i[0 +: DW] = 32'd55;
        req_valid_i[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall_resp_valid", resp_valid_o, 2'b10);
            chk("stall_result", resp_result_o, 123);
            chk("stall_req_ready", req_ready_o, 0);
            chk("stall_busy", busy_o, 1);
        end
        step();
        req_valid_i[0] = 1'b0;
        resp_ready_i[1] = 1'b1;
        wait_hs(1);
        step(2);

        // Spurious completion in IDLE, then in ISSUE.
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("spur_idle_busy", busy_o, 0);
            chk("spur_idle_resp", resp_valid_o, 0);
        end
        step();
        res_q.delete();
        send(0, 32'd77);
        chk("spur_issue_start", red_start_o, 1);
        spur = 1'b1;
        step();
        spur = 1'b0;
        wait_hs(0);
        chk("spur_issue_result", res_q[0], 77);
        step(2);

        // Reset while waiting on the unit.
        send(0, 32'd999);
        step();
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_start", red_start_o, 0);
        chk("async_rst_red_x", red_x_o, 0);
        chk("async_rst_resp_valid", resp_valid_o, 0);
        chk("async_rst_req_ready", req_ready_o, 0);
        step(2);
        rst_ni = 1'b1;
        step(6);
        res_q.delete();
        send(1, 32'd5);
        wait_hs(1);
        chk("post_rst_count", res_q.size(), 1);
        chk("post_rst_result", res_q[0], 5);
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
        $fatal(1);
    end

endmodule
